// File: rtl/nes_joypad_port_if.sv
// CPU-side access bus for the NES joypad port ($4016/$4017).
// The master drives the access strobe, direction, pad select and write data.
// The slave returns the read data.
interface nes_joypad_port_if;
    logic       ENABLE;
    logic       WR;
    logic       PAD_SEL;
    logic [7:0] bus;
    logic [7:0] DATA;

    modport master (output ENABLE, output WR, output PAD_SEL, output bus, input DATA);
    modport slave  (input ENABLE, input WR, input PAD_SEL, input bus, output DATA);
endinterface

// File: rtl/nes_joypad_port.sv
// NES two-pad controller port driven by USB HID keyboard keycodes.
// Keycodes are decoded through per-pad keymaps and registered into pressed_q.
// The $4016 strobe latch reloads both 8-bit shift registers.
// Each read of $4016/$4017 shifts one button out of the selected pad and shifts a 1 in.
// Optional feature: define NES_JOYPAD_TURBO_EN to add turbo A/B keys gated by a
// square wave whose half-period is TURBO_DIV clock cycles.
module nes_joypad_port #(
    parameter int          NUM_KEYS  = 6,
    parameter logic [63:0] KEYMAP0   = 64'h07_04_16_1A_1C_17_0B_0A,
    parameter logic [63:0] KEYMAP1   = 64'h4F_50_51_52_13_12_0F_0E,
    parameter logic [23:0] TURBO_DIV = 24'd447443
) (
    input  logic                  CLK,
    input  logic                  RESET,
    nes_joypad_port_if.slave      cpu,
    input  logic [8*NUM_KEYS-1:0] keycodes
);

    // A zero divider would make the turbo counter meaningless.
    if (TURBO_DIV == 24'd0) begin : g_bad_div
        $error("nes_joypad_port: TURBO_DIV must be nonzero");
    end

    // True when any nonzero keycode slot equals code.
    function automatic logic key_hit(input logic [7:0] code,
                                     input logic [8*NUM_KEYS-1:0] kc);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (kc[8*k +: 8] != 8'h00 && kc[8*k +: 8] == code)
                hit = 1'b1;
        end
        return hit;
    endfunction

    // Maps keycodes onto eight buttons; a zero keymap byte can never match.
    function automatic logic [7:0] decode_pad(input logic [63:0] map,
                                              input logic [8*NUM_KEYS-1:0] kc);
        logic [7:0] btn;
        btn = 8'h00;
        for (int b = 0; b < 8; b++)
            btn[b] = key_hit(map[8*b +: 8], kc);
        return btn;
    endfunction

    logic [1:0][7:0] pressed_q;
    logic [7:0]      dec0, dec1;
    logic [7:0]      turbo0, turbo1;
    logic            strobe_q;
    logic [7:0]      shift0, shift1;
    logic            rd;
    logic            live_bit;

`ifdef NES_JOYPAD_TURBO_EN
    logic [23:0] turbo_cnt;
    logic        turbo_phase;

    // Free-running turbo divider; phase toggles each time the count wraps.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            turbo_cnt   <= 24'd0;
            turbo_phase <= 1'b0;
        end else if (turbo_cnt == TURBO_DIV - 24'd1) begin
            turbo_cnt   <= 24'd0;
            turbo_phase <= ~turbo_phase;
        end else begin
            turbo_cnt   <= turbo_cnt + 24'd1;
        end
    end

    // Turbo keys only ever contribute to the A (bit 0) and B (bit 1) buttons.
    always_comb begin
        turbo0 = {6'b0, key_hit(8'h0C, keycodes) & turbo_phase,
                        key_hit(8'h0D, keycodes) & turbo_phase};
        turbo1 = {6'b0, key_hit(8'h36, keycodes) & turbo_phase,
                        key_hit(8'h10, keycodes) & turbo_phase};
    end
`else
    assign turbo0 = 8'h00;
    assign turbo1 = 8'h00;
`endif

    // Combinational keymap decode merged with any turbo buttons.
    always_comb begin
        dec0 = decode_pad(KEYMAP0, keycodes) | turbo0;
        dec1 = decode_pad(KEYMAP1, keycodes) | turbo1;
    end

    // Register the live button state once per clock.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pressed_q <= '0;
        end else begin
            pressed_q[0] <= dec0;
            pressed_q[1] <= dec1;
        end
    end

    assign rd = cpu.ENABLE & ~cpu.WR;

    // Strobe latch plus the two shift registers; strobe reload beats read shifting.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            strobe_q <= 1'b0;
            shift0   <= 8'h00;
            shift1   <= 8'h00;
        end else begin
            if (cpu.ENABLE && cpu.WR && !cpu.PAD_SEL)
                strobe_q <= cpu.bus[0];
            if (strobe_q) begin
                shift0 <= pressed_q[0];
                shift1 <= pressed_q[1];
            end else if (rd && !cpu.PAD_SEL) begin
                shift0 <= {1'b1, shift0[7:1]};
            end else if (rd && cpu.PAD_SEL) begin
                shift1 <= {1'b1, shift1[7:1]};
            end
        end
    end

    // While strobed, the A button is read live instead of from the shifter.
    always_comb begin
        if (strobe_q)
            live_bit = cpu.PAD_SEL ? pressed_q[1][0] : pressed_q[0][0];
        else
            live_bit = cpu.PAD_SEL ? shift1[0] : shift0[0];
    end

    assign cpu.DATA = {7'b0100000, live_bit};

    // Only bit 0 of the write data is meaningful for the strobe latch.
    wire unused_bus = &{1'b0, cpu.bus[7:1]};

endmodule

// File: tb/tb_nes_joypad_port.sv
// Scoreboard bench for nes_joypad_port: read stimulus pushes expected DATA,
// and a negedge monitor pops and compares on every read cycle.
module tb_nes_joypad_port;

    localparam int NUM_KEYS = 6;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;

    logic                  CLK = 1'b0;
    logic                  RESET = 1'b1;
    logic [8*NUM_KEYS-1:0] keycodes = '0;

    nes_joypad_port_if bus_if ();

    nes_joypad_port #(
        .NUM_KEYS  (NUM_KEYS),
        .TURBO_DIV (24'd4)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .cpu      (bus_if),
        .keycodes (keycodes)
    );

    always #5 CLK = ~CLK;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    bit   done_seen = 1'b0;

    // Monitor: every read cycle presents a value that must match the queue head.
    always @(negedge CLK) begin
        if (bus_if.ENABLE && !bus_if.WR) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read actual=%h required=no read", bus_if.DATA);
            end else begin
                cur = exp_q.pop_front();
                if (bus_if.DATA !== cur.exp) begin
                    errors++;
                    $display("FAIL %s actual=%h required=%h", cur.name, bus_if.DATA, cur.exp);
                end
            end
        end
        if (done && !done_seen) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
            end
            done_seen = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic sel, input logic [7:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
        bus_if.ENABLE  = 1'b1;
        bus_if.WR      = 1'b0;
        bus_if.PAD_SEL = sel;
        @(posedge CLK);
        #1;
        bus_if.ENABLE = 1'b0;
    endtask

    task automatic wr(input logic sel, input logic [7:0] val);
        bus_if.ENABLE  = 1'b1;
        bus_if.WR      = 1'b1;
        bus_if.PAD_SEL = sel;
        bus_if.bus     = val;
        @(posedge CLK);
        #1;
        bus_if.ENABLE = 1'b0;
        bus_if.WR     = 1'b0;
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    logic [7:0] seq_g  [8] = '{1, 0, 0, 0, 0, 1, 0, 0};
    logic [7:0] seq_p1 [8] = '{0, 1, 0, 0, 1, 0, 0, 0};
    logic       gpat   [6] = '{1, 1, 0, 1, 0, 1};
    logic [7:0] turbo_exp [8];

    initial begin
        bus_if.ENABLE  = 1'b0;
        bus_if.WR      = 1'b0;
        bus_if.PAD_SEL = 1'b0;
        bus_if.bus     = 8'h00;
`ifdef NES_JOYPAD_TURBO_EN
        turbo_exp = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41, 8'h41};
`else
        turbo_exp = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
`endif

        // Reset state on both ports.
        idle(3);
        RESET = 1'b0;
        rd(1'b0, 8'h40, "reset_4016");
        rd(1'b1, 8'h40, "reset_4017");

        // Pad 0: G and S held -> A and Down.
        keycodes = {8'h0A, 8'h16, 32'h0};
        idle(2);
        wr(1'b0, 8'h01);
        wr(1'b0, 8'h00);
        for (int i = 0; i < 8; i++)
            rd(1'b0, 8'h40 | seq_g[i], $sformatf("pad0_bit%0d", i));
        rd(1'b0, 8'h41, "pad0_read9");
        rd(1'b0, 8'h41, "pad0_read10");
        // A $4017 write must not touch the strobe.
        wr(1'b1, 8'h01);
        rd(1'b0, 8'h41, "wr4017_ignored");

        // Pad 1: Up arrow and L, with $4016 reads interleaved.
        keycodes = {8'h52, 8'h0F, 32'h0};
        idle(2);
        wr(1'b0, 8'h01);
        wr(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            rd(1'b1, 8'h40 | seq_p1[i], $sformatf("pad1_bit%0d", i));
            if (i < 3)
                rd(1'b0, 8'h40, $sformatf("pad0_interleave%0d", i));
        end
        rd(1'b1, 8'h41, "pad1_read9");

        // Strobe held high: reads track G with one cycle of lag and never shift.
        keycodes = '0;
        idle(2);
        wr(1'b0, 8'h01);
        for (int i = 0; i < 6; i++) begin
            keycodes = gpat[i] ? {8'h0A, 40'h0} : '0;
            rd(1'b0, (i == 0) ? 8'h40 : (8'h40 | {7'b0, gpat[i-1]}),
               $sformatf("strobe_live%0d", i));
        end
        wr(1'b0, 8'h00);
        for (int i = 0; i < 8; i++)
            rd(1'b0, (i == 0) ? 8'h41 : 8'h40, $sformatf("latched_bit%0d", i));
        rd(1'b0, 8'h41, "latched_read9");

        // Reset in the middle of a read sequence.
        keycodes = {8'h0A, 8'h16, 32'h0};
        idle(2);
        wr(1'b0, 8'h01);
        wr(1'b0, 8'h00);
        for (int i = 0; i < 3; i++)
            rd(1'b0, 8'h40 | seq_g[i], $sformatf("pre_reset_bit%0d", i));
        pulse_reset();
        rd(1'b0, 8'h40, "post_reset_4016");
        rd(1'b1, 8'h40, "post_reset_4017");

        // All-zero keycodes never match anything.
        keycodes = '0;
        idle(2);
        wr(1'b0, 8'h01);
        wr(1'b0, 8'h00);
        for (int i = 0; i < 8; i++)
            rd(1'b0, 8'h40, $sformatf("zero_keys_bit%0d", i));

        // Turbo A (J) polled with strobe high, starting right after reset.
        keycodes = {8'h0D, 40'h0};
        idle(2);
        pulse_reset();
        wr(1'b0, 8'h01);
        for (int i = 0; i < 8; i++)
            rd(1'b0, turbo_exp[i], $sformatf("turbo_poll%0d", i));

        done = 1'b1;
        repeat (3) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_joypad_port.md
Name: nes_joypad_port

Overview:
- Parametrised two-pad NES controller port emulation driven by USB HID keyboard keycodes.
- Maps up to NUM_KEYS simultaneous keycodes onto two 8-button pads through parameterised keymaps.
- Implements the $4016 strobe latch and the per-pad 8-bit serial shift registers read at $4016/$4017.
- Sits between the CPU bus decode (ENABLE/WR/PAD_SEL) and the keyboard host interface.

Parameters:
- NUM_KEYS, 6, number of 8-bit keycode slots presented on keycodes.
- KEYMAP0, 64'h07_04_16_1A_1C_17_0B_0A, pad 0 keycodes. Byte i maps to button i. Order: bit0 A(G), 1 B(H), 2 Select(T), 3 Start(Y), 4 Up(W), 5 Down(S), 6 Left(A), 7 Right(D).
- KEYMAP1, 64'h4F_50_51_52_13_12_0F_0E, pad 1 keycodes in the same order: K, L, O, P, Up, Down, Left, Right arrows.
- TURBO_DIV, 24'd447443, CLK cycles per turbo half-period (only used with TURBO_EN).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  single-cycle CPU access strobe for $4016/$4017.
- WR  in  1  1 = write access, 0 = read access (qualified by ENABLE).
- PAD_SEL  in  1  address bit 0: 0 = $4016/pad 0, 1 = $4017/pad 1.
- bus  in  8  CPU write data.
- keycodes  in  8*NUM_KEYS  current HID keycodes; slot k is bits [8k+7:8k].
- DATA  out  8  read data.

Behaviour:
- Reset: strobe_q=0, pressed_q[1:0]=0, shift0=shift1=8'h00, turbo counter and phase=0. DATA=8'h40.
- Key decode (combinational): button b of pad p is set if any slot equals byte b of KEYMAPp and that keycode is nonzero. Keycode 8'h00 never matches, and a zero keymap byte disables that button.
- pressed_q[p] registers the decode every CLK, giving 1 cycle of latency from keycodes.
- Write: ENABLE&WR&!PAD_SEL sets strobe_q<=bus[0]. A write with PAD_SEL=1 is ignored (APU frame counter owns $4017 writes).
- Shift registers, priority order per edge:
  - strobe_q==1: shiftN<=pressed_q[N] on every edge. This includes the edge ending a write of 0, so the final reload uses the current pressed_q.
  - Else, a read (ENABLE&!WR) of pad N sets shiftN<={1'b1, shiftN[7:1]}. The other pad is untouched.
  - Else, hold.
- A read while strobe_q==1 does not shift. It returns bit0 (A) of the live pressed state.
- DATA is combinational: {7'b0100000, shiftS[0]} with S=PAD_SEL.
  - Valid in the ENABLE read cycle; the shift takes effect at the edge ending that cycle.
  - While strobe_q==1, DATA[0]=pressed_q[S][0].
- After 8 reads without strobe, all further reads return DATA=8'h41 (1s shifted in) until the next strobe.
- Simultaneous key hold with opposite directions is passed through unmodified.
- RESET during a read sequence wins over everything: the next read returns 8'h40.
- ENABLE low: no state change except pressed_q and turbo counter.

Optional Feature:
- Macro: NES_JOYPAD_TURBO_EN.
- Enabled adds:
  - Turbo keycodes for pad 0: 8'h0D (J) = turbo A, 8'h0E reassignment not allowed.
  - Turbo keycodes for pad 1: 8'h10 (M) = turbo A, 8'h36 (,) = turbo B.
  - Turbo keycodes for pad 0 turbo B: 8'h0C (I).
  - A 24-bit counter counts to TURBO_DIV-1, then wraps to 0 and toggles turbo phase.
  - Turbo buttons OR (turbo_pressed & phase) into the A/B bits before pressed_q.
  - Counter and phase reset to 0.
- Disabled: no counter, turbo keycodes decode to nothing, TURBO_DIV unused.

Test Plan:
- Reset, then read $4016 -> DATA=8'h40; read $4017 -> 8'h40.
- keycodes={8'h0A,8'h16,0,0,0,0} (G,S), write $4016=1 then 0, 8 reads $4016 -> DATA[0] sequence 1,0,0,0,0,1,0,0; 9th and 10th reads -> 8'h41.
- keycodes={8'h52,8'h0F,...}, strobe 1/0, 8 reads $4017 -> 0,1,0,0,1,0,0,0. Interleaved $4016 reads do not disturb pad 1 order.
- Strobe held at 1, key G toggled, repeated reads -> DATA[0] tracks G with 1-cycle lag and no shifting. After strobe 0, 8 reads give the latched state.
- Assert RESET after 3 of 8 reads -> next read 8'h40. Keycodes all 8'h00 with KEYMAP byte 0 -> no button set.
- NES_JOYPAD_TURBO_EN, TURBO_DIV=4, hold J, strobe each cycle. Polled A toggles every 4 CLK: 0,0,0,0,1,1,1,1. Without the macro, A stays 0.
